// File: rtl/mod_updown_counter_pkg.sv
// Shared definitions for the up/down counter family: direction/mode macros and the per-edge operation type.
// The macros are guarded so that later timer blocks can reuse them.
`ifndef COUNTER_DEFS_VH
`define COUNTER_DEFS_VH
`define CNT_DIR_UP    1'b1
`define CNT_DIR_DN    1'b0
`define CNT_MODE_WRAP 0
`define CNT_MODE_SAT  1
`endif

package mod_updown_counter_pkg;

    // Operation applied to the count register on a given edge, in priority order.
    typedef enum logic [1:0] {
        CNT_HOLD  = 2'd0,
        CNT_CLEAR = 2'd1,
        CNT_LOAD  = 2'd2,
        CNT_STEP  = 2'd3
    } cnt_op_e;

    // Width of the prescaler phase register; at least one bit.
    function automatic int ps_width(input int prescale);
        int w;
        w = $clog2(prescale);
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/mod_updown_counter_tick_prescaler.sv
// Enable prescaler: emits a one-cycle tick every PRESCALE enabled cycles.
// With PRESCALE=1 there is no state and the tick is the enable itself.
module tick_prescaler
    import mod_updown_counter_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic sync_zero,
    output logic tick
);

    generate
        if (PRESCALE > 1) begin : g_div
            localparam int PS_W = ps_width(PRESCALE);
            localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

            logic [PS_W-1:0] ps;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    ps <= '0;
                end else if (sync_zero) begin
                    ps <= '0;
                end else if (en) begin
                    ps <= (ps == PS_LAST) ? '0 : ps + PS_W'(1);
                end
            end

            assign tick = en & (ps == PS_LAST);
        end else begin : g_bypass
            // Clock/reset/zero are meaningless without a phase register.
            logic unused_inputs;
            assign unused_inputs = ^{clk, rst, sync_zero};
            assign tick = en;
        end
    endgenerate

endmodule

// File: rtl/mod_updown_counter.sv
// Parametrised up/down counter with programmable modulus, wrap/saturate, load, clear,
// enable prescaler, registered terminal-count pulse and sticky overflow flag.
module mod_updown_counter
    import mod_updown_counter_pkg::*;
#(
    parameter int              WIDTH    = 8,
    parameter longint unsigned MODULUS  = 256,
    parameter int              PRESCALE = 1,
    parameter int              SATURATE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             ovf_clr,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             ovf
);

    // Upper bound held at WIDTH bits so MODULUS = 2**WIDTH never overflows the compare.
    localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULUS - 64'd1);

    logic             tick;
    cnt_op_e          op;
    logic [WIDTH-1:0] count_next;
    logic             boundary;
    logic             tc_next;
    logic             ovf_next;

    tick_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_tick_prescaler (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .sync_zero (clr | load),
        .tick      (tick)
    );

    always_comb begin
        op = CNT_HOLD;
        if (clr) begin
            op = CNT_CLEAR;
        end else if (load) begin
            op = CNT_LOAD;
        end else if (tick) begin
            op = CNT_STEP;
        end
    end

    always_comb begin
        count_next = count;
        boundary   = 1'b0;
        case (op)
            CNT_CLEAR: count_next = '0;
            CNT_LOAD:  count_next = (load_val > MAX_CNT) ? MAX_CNT : load_val;
            CNT_STEP: begin
                if (up == `CNT_DIR_UP) begin
                    if (count == MAX_CNT) begin
                        boundary = 1'b1;
                        if (SATURATE == `CNT_MODE_WRAP) begin
                            count_next = '0;
                        end
                    end else begin
                        count_next = count + WIDTH'(1);
                    end
                end else begin
                    if (count == '0) begin
                        boundary = 1'b1;
                        if (SATURATE == `CNT_MODE_WRAP) begin
                            count_next = MAX_CNT;
                        end
                    end else begin
                        count_next = count - WIDTH'(1);
                    end
                end
            end
            default: count_next = count;
        endcase
        // A new boundary step beats a simultaneous ovf_clr.
        tc_next  = boundary;
        ovf_next = boundary | (ovf & ~ovf_clr);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            tc    <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            count <= count_next;
            tc    <= tc_next;
            ovf   <= ovf_next;
        end
    end

endmodule

// File: tb/tb_mod_updown_counter.sv
// Bench for mod_updown_counter: four configurations share one stimulus stream and are
// tracked by an arithmetic reference model; table vectors and hand sequences add fixed expectations.
module tb_mod_updown_counter;

    logic       clk;
    logic       rst;
    logic       en;
    logic       up;
    logic       clr;
    logic       load;
    logic [3:0] load_val;
    logic       ovf_clr;

    logic [3:0] c_a, c_s, c_p, c_f;
    logic       tc_a, tc_s, tc_p, tc_f;
    logic       ov_a, ov_s, ov_p, ov_f;

    int passed;
    int total;

    // Reference model state, one slot per DUT: 0=wrap M10, 1=sat M10, 2=prescale4 M10, 3=wrap M16.
    int m_mod [4] = '{10, 10, 10, 16};
    int m_pre [4] = '{1, 1, 4, 1};
    int m_sat [4] = '{0, 1, 0, 0};
    int m_cnt [4];
    int m_ps  [4];
    int m_tc  [4];
    int m_ovf [4];

    typedef struct {
        logic       clr;
        logic       load;
        logic [3:0] load_val;
        logic       en;
        logic       up;
        logic       ovf_clr;
        int         exp_count;
        int         exp_tc;
        int         exp_ovf;
    } vec_t;

    vec_t vecs[$];

    mod_updown_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(1), .SATURATE(0)) dut_a (
        .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load),
        .load_val(load_val), .ovf_clr(ovf_clr), .count(c_a), .tc(tc_a), .ovf(ov_a));
    mod_updown_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(1), .SATURATE(1)) dut_s (
        .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load),
        .load_val(load_val), .ovf_clr(ovf_clr), .count(c_s), .tc(tc_s), .ovf(ov_s));
    mod_updown_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(4), .SATURATE(0)) dut_p (
        .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load),
        .load_val(load_val), .ovf_clr(ovf_clr), .count(c_p), .tc(tc_p), .ovf(ov_p));
    mod_updown_counter #(.WIDTH(4), .MODULUS(16), .PRESCALE(1), .SATURATE(0)) dut_f (
        .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load),
        .load_val(load_val), .ovf_clr(ovf_clr), .count(c_f), .tc(tc_f), .ovf(ov_f));

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int exp);
        total++;
        if (got == exp) begin
            passed++;
        end else begin
            $display("FAIL %s got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            m_cnt[k] = 0;
            m_ps[k]  = 0;
            m_tc[k]  = 0;
            m_ovf[k] = 0;
        end
    endtask

    // One rising edge of the behavioural model using the inputs currently driven.
    task automatic model_edge();
        for (int k = 0; k < 4; k++) begin
            int hit;
            hit = 0;
            if (clr) begin
                m_cnt[k] = 0;
                m_ps[k]  = 0;
            end else if (load) begin
                m_cnt[k] = (int'(load_val) < m_mod[k]) ? int'(load_val) : m_mod[k] - 1;
                m_ps[k]  = 0;
            end else if (en) begin
                m_ps[k] = m_ps[k] + 1;
                if (m_ps[k] == m_pre[k]) begin
                    m_ps[k] = 0;
                    if (up) begin
                        if (m_cnt[k] + 1 >= m_mod[k]) begin
                            hit = 1;
                            m_cnt[k] = m_sat[k] ? m_cnt[k] : 0;
                        end else begin
                            m_cnt[k] = m_cnt[k] + 1;
                        end
                    end else begin
                        if (m_cnt[k] - 1 < 0) begin
                            hit = 1;
                            m_cnt[k] = m_sat[k] ? m_cnt[k] : m_mod[k] - 1;
                        end else begin
                            m_cnt[k] = m_cnt[k] - 1;
                        end
                    end
                end
            end
            m_tc[k]  = hit;
            m_ovf[k] = (hit != 0 || (m_ovf[k] != 0 && !ovf_clr)) ? 1 : 0;
        end
    endtask

    task automatic check_model();
        chk("model_a_count", int'(c_a), m_cnt[0]);
        chk("model_a_tc", int'(tc_a), m_tc[0]);
        chk("model_a_ovf", int'(ov_a), m_ovf[0]);
        chk("model_s_count", int'(c_s), m_cnt[1]);
        chk("model_s_tc", int'(tc_s), m_tc[1]);
        chk("model_s_ovf", int'(ov_s), m_ovf[1]);
        chk("model_p_count", int'(c_p), m_cnt[2]);
        chk("model_p_tc", int'(tc_p), m_tc[2]);
        chk("model_p_ovf", int'(ov_p), m_ovf[2]);
        chk("model_f_count", int'(c_f), m_cnt[3]);
        chk("model_f_tc", int'(tc_f), m_tc[3]);
        chk("model_f_ovf", int'(ov_f), m_ovf[3]);
    endtask

    // Driver: advance one edge, update the model, compare all DUTs.
    task automatic tick();
        @(posedge clk);
        #1;
        model_edge();
        check_model();
    endtask

    task automatic drive(input logic c, input logic l, input logic [3:0] lv,
                         input logic e, input logic u, input logic oc);
        clr = c; load = l; load_val = lv; en = e; up = u; ovf_clr = oc;
    endtask

    task automatic add_vec(input logic c, input logic l, input logic [3:0] lv, input logic e,
                           input logic u, input logic oc, input int ec, input int et, input int eo);
        vec_t v;
        v.clr = c; v.load = l; v.load_val = lv; v.en = e; v.up = u; v.ovf_clr = oc;
        v.exp_count = ec; v.exp_tc = et; v.exp_ovf = eo;
        vecs.push_back(v);
    endtask

    initial begin
        passed = 0;
        total  = 0;
        rst = 1'b1;
        drive(0, 0, 4'd0, 0, 1, 0);
        model_reset();

        // Expected behaviour of the wrap, M=10, P=1 counter starting from reset.
        for (int i = 1; i <= 12; i++) begin
            add_vec(0, 0, 4'd0, 1, 1, 0, i % 10, (i == 10) ? 1 : 0, (i >= 10) ? 1 : 0);
        end
        add_vec(0, 0, 4'd0, 0, 1, 1, 2, 0, 0);   // ovf_clr alone
        add_vec(0, 0, 4'd0, 1, 0, 0, 1, 0, 0);
        add_vec(0, 0, 4'd0, 1, 0, 0, 0, 0, 0);
        add_vec(0, 0, 4'd0, 1, 0, 0, 9, 1, 1);   // underflow wraps to 9
        add_vec(0, 0, 4'd0, 1, 0, 0, 8, 0, 1);
        add_vec(0, 1, 4'd12, 0, 1, 0, 9, 0, 1);  // clamped load
        add_vec(1, 1, 4'd5, 1, 1, 0, 0, 0, 1);   // clr beats load
        add_vec(0, 1, 4'd5, 1, 1, 0, 5, 0, 1);   // load beats step
        add_vec(0, 0, 4'd0, 1, 1, 1, 6, 0, 0);
        add_vec(0, 1, 4'd9, 0, 1, 0, 9, 0, 0);
        add_vec(0, 0, 4'd0, 1, 1, 1, 0, 1, 1);   // set beats ovf_clr
        add_vec(0, 0, 4'd0, 0, 1, 0, 0, 0, 1);

        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_count", int'(c_a), 0);
        chk("reset_tc", int'(tc_a), 0);
        chk("reset_ovf", int'(ov_a), 0);
        chk("reset_count_p", int'(c_p), 0);

        foreach (vecs[i]) begin
            drive(vecs[i].clr, vecs[i].load, vecs[i].load_val, vecs[i].en, vecs[i].up, vecs[i].ovf_clr);
            tick();
            chk($sformatf("vec%0d_count", i), int'(c_a), vecs[i].exp_count);
            chk($sformatf("vec%0d_tc", i), int'(tc_a), vecs[i].exp_tc);
            chk($sformatf("vec%0d_ovf", i), int'(ov_a), vecs[i].exp_ovf);
        end

        // Saturating counter held at the top and bottom.
        drive(0, 1, 4'd8, 0, 1, 0); tick();
        drive(0, 0, 4'd0, 1, 1, 0);
        tick(); chk("sat_up1_count", int'(c_s), 9); chk("sat_up1_tc", int'(tc_s), 0);
        tick(); chk("sat_up2_count", int'(c_s), 9); chk("sat_up2_tc", int'(tc_s), 1);
        tick(); chk("sat_up3_count", int'(c_s), 9); chk("sat_up3_tc", int'(tc_s), 1);
        chk("sat_ovf", int'(ov_s), 1);
        drive(0, 1, 4'd0, 0, 0, 0); tick();
        drive(0, 0, 4'd0, 1, 0, 0);
        tick(); chk("sat_dn_count", int'(c_s), 0); chk("sat_dn_tc", int'(tc_s), 1);

        // Full-range modulus wraps 15 -> 0.
        drive(0, 1, 4'd15, 0, 1, 0); tick();
        chk("full_load_count", int'(c_f), 15);
        drive(0, 0, 4'd0, 1, 1, 0);
        tick(); chk("full_wrap_count", int'(c_f), 0); chk("full_wrap_tc", int'(tc_f), 1);

        // Prescaler: continuous enable steps every 4th edge.
        drive(1, 0, 4'd0, 0, 1, 0); tick();
        drive(0, 0, 4'd0, 1, 1, 0);
        for (int i = 1; i <= 8; i++) begin
            tick();
            chk($sformatf("pre_cont%0d", i), int'(c_p), i / 4);
        end
        // Alternating enable: one step per 8 edges.
        for (int i = 0; i < 8; i++) begin
            en = (i % 2 == 0);
            tick();
            chk($sformatf("pre_alt%0d", i), int'(c_p), (i >= 6) ? 3 : 2);
        end
        // clr at phase 2 restarts the prescale period.
        en = 1'b1;
        tick(); tick();
        chk("pre_before_clr", int'(c_p), 3);
        clr = 1'b1; tick(); chk("pre_clr", int'(c_p), 0);
        clr = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk($sformatf("pre_after_clr%0d", i), int'(c_p), (i == 4) ? 1 : 0);
        end

        // Random stimulus against the model.
        for (int n = 0; n < 400; n++) begin
            drive(($urandom_range(0, 29) == 0), ($urandom_range(0, 14) == 0),
                  4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0));
            tick();
        end

        // Asynchronous reset between edges takes effect without a clock edge.
        drive(0, 1, 4'd7, 0, 1, 0); tick();
        drive(0, 0, 4'd0, 0, 1, 0);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        chk("async_count_a", int'(c_a), 0);
        chk("async_count_s", int'(c_s), 0);
        chk("async_count_p", int'(c_p), 0);
        chk("async_count_f", int'(c_f), 0);
        chk("async_tc", int'(tc_a), 0);
        chk("async_ovf", int'(ov_a | ov_s | ov_p | ov_f), 0);
        @(negedge clk);
        rst = 1'b0;
        drive(0, 0, 4'd0, 1, 1, 0);
        tick();
        chk("post_reset_count", int'(c_a), 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
